// File: rtl/hpi_pkg.sv
// hpi_pkg
//  Shared definitions for the CY7C67300 HPI bus arbiter: HPI register codes,
//  sequencer state encoding, access phase flag and a small index-width helper.
//  No ports.
package hpi_pkg;

    localparam logic [1:0] HPI_REG_DATA    = 2'b00;
    localparam logic [1:0] HPI_REG_MAILBOX = 2'b01;
    localparam logic [1:0] HPI_REG_ADDRESS = 2'b10;
    localparam logic [1:0] HPI_REG_STATUS  = 2'b11;

    // Width of the SETUP/STROBE/RECOV down-counter.
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_RECOV  = 3'd4,
        ST_DONE   = 3'd5
    } hpi_state_t;

    // PH_ADDR: ADDRESS-register write of a memory access; PH_DATA: the final HPI cycle.
    typedef enum logic {
        PH_ADDR = 1'b0,
        PH_DATA = 1'b1
    } hpi_phase_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hpi_rr_arbiter.sv
// hpi_rr_arbiter
//  Combinational round-robin pick: the first requester at or after ptr wins.
//  Ports:
//   req  in  NREQ  request vector
//   ptr  in  IW    highest-priority index this round
//   gnt  out NREQ  one-hot winner (0 when no request)
//   idx  out IW    binary index of the winner
module hpi_rr_arbiter
    import hpi_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] pos;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // (ptr + k) mod NREQ without a divider; ptr < NREQ so one subtract suffices.
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            pos = sum[IW-1:0];
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/hpi_bus_arbiter.sv
// hpi_bus_arbiter
//  Shares the single CY7C67300 HPI port between NREQ requesters (round-robin)
//  and sequences each access on the HPI pins.
//   register access: one SETUP/STROBE/RECOV cycle on the requested HPI register
//   memory access  : ADDRESS-register write of req_addr, then DATA read/write
//  Optional feature macro: HPI_IRQ_MBX_EN (hpi_irq edge triggers a MAILBOX read
//  that takes priority over all requesters). Undefined: hpi_irq ignored,
//  mbx_valid/mbx_data tied to 0.
//  Ports:
//   clk, reset (async, active-high)
//   req/req_rw/req_mem [NREQ], req_reg [2*NREQ], req_addr/req_wdata [16*NREQ]
//   gnt [NREQ] one-hot owner, done pulse, rdata [16], busy
//   mbx_valid pulse, mbx_data [16]
//   hpi_address [2], hpi_data [16] inout, hpi_oen/hpi_wen/hpi_csn, hpi_resetn, hpi_irq
//
//  state     | meaning
//  ST_IDLE   | no access; arbitrate (mailbox first when enabled)
//  ST_GRANT  | gnt registered, fields latched; pins still idle
//  ST_SETUP  | csn low, address (and write data) stable
//  ST_STROBE | wen or oen low
//  ST_RECOV  | strobe released; write data still driven
//  ST_DONE   | done / mbx_valid pulse, gnt still asserted
module hpi_bus_arbiter
    import hpi_pkg::*;
#(
    parameter  int NREQ       = 2,
    parameter  int SETUP_CYC  = 1,
    parameter  int STROBE_CYC = 1,
    parameter  int RECOV_CYC  = 1,
    localparam int IW         = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_rw,
    input  logic [NREQ-1:0]      req_mem,
    input  logic [2*NREQ-1:0]    req_reg,
    input  logic [16*NREQ-1:0]   req_addr,
    input  logic [16*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic                 done,
    output logic [15:0]          rdata,
    output logic                 busy,
    output logic                 mbx_valid,
    output logic [15:0]          mbx_data,
    output logic [1:0]           hpi_address,
    inout  wire  [15:0]          hpi_data,
    output logic                 hpi_oen,
    output logic                 hpi_wen,
    output logic                 hpi_csn,
    output logic                 hpi_resetn,
    input  logic                 hpi_irq
);

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LD  = CNT_W'(RECOV_CYC - 1);

    hpi_state_t       state;
    hpi_phase_t       phase;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    cur_idx;
    logic [IW-1:0]    next_ptr;
    logic             cur_rw;
    logic             cur_mem;
    logic [1:0]       cur_reg;
    logic [15:0]      cur_addr;
    logic [15:0]      cur_wdata;
    logic             data_oe;
    logic [15:0]      data_out;

    logic [NREQ-1:0]  arb_gnt;
    logic [IW-1:0]    arb_idx;

    logic [1:0]       reg_v   [NREQ];
    logic [15:0]      addr_v  [NREQ];
    logic [15:0]      wdata_v [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign reg_v[g]   = req_reg[2*g +: 2];
        assign addr_v[g]  = req_addr[16*g +: 16];
        assign wdata_v[g] = req_wdata[16*g +: 16];
    end

    hpi_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign next_ptr   = (cur_idx == IW'(NREQ - 1)) ? '0 : cur_idx + IW'(1);
    assign hpi_data   = data_oe ? data_out : 16'hzzzz;
    assign hpi_resetn = ~reset;

`ifdef HPI_IRQ_MBX_EN
    logic        mbx_xfer;
    logic        mbx_pend;
    logic        mbx_valid_r;
    logic [15:0] mbx_data_r;
    // [0],[1] synchroniser, [2] previous value for edge detect
    logic [2:0]  irq_sync;
    logic        irq_rise;

    assign irq_rise  = irq_sync[1] & ~irq_sync[2];
    assign mbx_valid = mbx_valid_r;
    assign mbx_data  = mbx_data_r;
`else
    logic unused_irq;

    assign unused_irq = hpi_irq;
    assign mbx_valid  = 1'b0;
    assign mbx_data   = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase       <= PH_DATA;
            cnt         <= '0;
            ptr         <= '0;
            cur_idx     <= '0;
            cur_rw      <= 1'b0;
            cur_mem     <= 1'b0;
            cur_reg     <= HPI_REG_STATUS;
            cur_addr    <= '0;
            cur_wdata   <= '0;
            gnt         <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            rdata       <= '0;
            hpi_address <= HPI_REG_STATUS;
            hpi_csn     <= 1'b1;
            hpi_oen     <= 1'b1;
            hpi_wen     <= 1'b1;
            data_oe     <= 1'b0;
            data_out    <= '0;
`ifdef HPI_IRQ_MBX_EN
            mbx_xfer    <= 1'b0;
            mbx_pend    <= 1'b0;
            mbx_valid_r <= 1'b0;
            mbx_data_r  <= '0;
            irq_sync    <= '0;
`endif
        end else begin
            done <= 1'b0;
`ifdef HPI_IRQ_MBX_EN
            mbx_valid_r <= 1'b0;
            irq_sync    <= {irq_sync[1:0], hpi_irq};
`endif
            case (state)
                ST_IDLE: begin
`ifdef HPI_IRQ_MBX_EN
                    if (mbx_pend) begin
                        // Mailbox read owns the bus without a requester grant.
                        mbx_xfer <= 1'b1;
                        cur_rw   <= 1'b0;
                        cur_mem  <= 1'b0;
                        cur_reg  <= HPI_REG_MAILBOX;
                        busy     <= 1'b1;
                        state    <= ST_GRANT;
                    end else
`endif
                    if (|req) begin
                        gnt       <= arb_gnt;
                        cur_idx   <= arb_idx;
                        cur_rw    <= req_rw[arb_idx];
                        cur_mem   <= req_mem[arb_idx];
                        cur_reg   <= reg_v[arb_idx];
                        cur_addr  <= addr_v[arb_idx];
                        cur_wdata <= wdata_v[arb_idx];
                        busy      <= 1'b1;
                        state     <= ST_GRANT;
`ifdef HPI_IRQ_MBX_EN
                        mbx_xfer  <= 1'b0;
`endif
                    end
                end

                ST_GRANT: begin
                    hpi_csn <= 1'b0;
                    cnt     <= SETUP_LD;
                    state   <= ST_SETUP;
                    if (cur_mem) begin
                        phase       <= PH_ADDR;
                        hpi_address <= HPI_REG_ADDRESS;
                        data_out    <= cur_addr;
                        data_oe     <= 1'b1;
                    end else begin
                        phase       <= PH_DATA;
                        hpi_address <= cur_reg;
                        data_out    <= cur_wdata;
                        data_oe     <= cur_rw;
                    end
                end

                ST_SETUP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt   <= STROBE_LD;
                        state <= ST_STROBE;
                        if (phase == PH_ADDR || cur_rw) begin
                            hpi_wen <= 1'b0;
                        end else begin
                            hpi_oen <= 1'b0;
                        end
                    end
                end

                ST_STROBE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        hpi_wen <= 1'b1;
                        hpi_oen <= 1'b1;
                        cnt     <= RECOV_LD;
                        state   <= ST_RECOV;
                        // Sample on the last strobe cycle while the chip is still driving.
                        if (phase == PH_DATA && !cur_rw) begin
`ifdef HPI_IRQ_MBX_EN
                            if (mbx_xfer) begin
                                mbx_data_r <= hpi_data;
                            end else
`endif
                            begin
                                rdata <= hpi_data;
                            end
                        end
                    end
                end

                ST_RECOV: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (phase == PH_ADDR) begin
                        phase       <= PH_DATA;
                        hpi_address <= HPI_REG_DATA;
                        data_out    <= cur_wdata;
                        data_oe     <= cur_rw;
                        cnt         <= SETUP_LD;
                        state       <= ST_SETUP;
                    end else begin
                        hpi_csn     <= 1'b1;
                        data_oe     <= 1'b0;
                        hpi_address <= HPI_REG_STATUS;
                        state       <= ST_DONE;
`ifdef HPI_IRQ_MBX_EN
                        if (mbx_xfer) begin
                            mbx_valid_r <= 1'b1;
                        end else
`endif
                        begin
                            done <= 1'b1;
                            ptr  <= next_ptr;
                        end
                    end
                end

                ST_DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
`ifdef HPI_IRQ_MBX_EN
            // A new edge wins over the clear so an IRQ during the mailbox read is not lost.
            if (irq_rise) begin
                mbx_pend <= 1'b1;
            end else if (state == ST_DONE && mbx_xfer) begin
                mbx_pend <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hpi_bus_arbiter.sv
// tb_hpi_bus_arbiter
//  Scoreboarded bench for hpi_bus_arbiter with a behavioural CY7C67300 HPI model.
//  Build with or without HPI_IRQ_MBX_EN; expectations follow the same macro.
module tb_hpi_bus_arbiter;
    import hpi_pkg::*;

    localparam int NREQ = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      req_rw = '0;
    logic [NREQ-1:0]      req_mem = '0;
    logic [1:0]           t_reg   [NREQ];
    logic [15:0]          t_addr  [NREQ];
    logic [15:0]          t_wdata [NREQ];
    logic [2*NREQ-1:0]    req_reg;
    logic [16*NREQ-1:0]   req_addr;
    logic [16*NREQ-1:0]   req_wdata;
    logic [NREQ-1:0]      gnt;
    logic                 done, busy, mbx_valid;
    logic [15:0]          rdata, mbx_data;
    logic [1:0]           hpi_address;
    wire  [15:0]          hpi_data;
    logic                 hpi_oen, hpi_wen, hpi_csn, hpi_resetn;
    logic                 hpi_irq = 1'b0;

    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign req_reg[2*g +: 2]    = t_reg[g];
        assign req_addr[16*g +: 16] = t_addr[g];
        assign req_wdata[16*g +: 16] = t_wdata[g];
    end

    hpi_bus_arbiter #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_rw      (req_rw),
        .req_mem     (req_mem),
        .req_reg     (req_reg),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .rdata       (rdata),
        .busy        (busy),
        .mbx_valid   (mbx_valid),
        .mbx_data    (mbx_data),
        .hpi_address (hpi_address),
        .hpi_data    (hpi_data),
        .hpi_oen     (hpi_oen),
        .hpi_wen     (hpi_wen),
        .hpi_csn     (hpi_csn),
        .hpi_resetn  (hpi_resetn),
        .hpi_irq     (hpi_irq)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- chip model ----------------
    logic [15:0] mem [256];
    logic [15:0] chip_addr = 16'h0000;
    logic [15:0] chip_mbx  = 16'h5A3C;
    logic [15:0] host_mbx  = 16'h0000;
    logic [1:0]  last_wr_sel  = 2'b00;
    logic [15:0] last_wr_data = 16'h0000;
    logic [15:0] chip_rd;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h24] = 16'hBEEF;
    end

    always_comb begin
        chip_rd = 16'hC0DE;
        case (hpi_address)
            HPI_REG_DATA:    chip_rd = mem[chip_addr[7:0]];
            HPI_REG_MAILBOX: chip_rd = chip_mbx;
            HPI_REG_ADDRESS: chip_rd = chip_addr;
            default:         chip_rd = 16'hC0DE;
        endcase
    end

    assign hpi_data = (!hpi_oen && !hpi_csn) ? chip_rd : 16'hzzzz;

    always @(posedge hpi_wen) begin
        if (!hpi_csn && !reset) begin
            last_wr_sel  = hpi_address;
            last_wr_data = hpi_data;
            case (hpi_address)
                HPI_REG_ADDRESS: chip_addr = hpi_data;
                HPI_REG_DATA:    mem[chip_addr[7:0]] = hpi_data;
                HPI_REG_MAILBOX: host_mbx = hpi_data;
                default: ;
            endcase
        end
    end

    // ---------------- monitors ----------------
    int cyc = 0;
    int busy_start = 0;
    logic busy_q = 1'b0;
    int n_done = 0;
    int n_mbx = 0;
    int wen_run = 0;
    int last_wen_len = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (busy && !busy_q) busy_start = cyc;
        busy_q = busy;
        if (done) n_done++;
        if (mbx_valid) n_mbx++;
        if (!hpi_oen && !hpi_wen) chk("oen_wen_overlap", 32'd1, 32'd0);
        if (!hpi_wen) wen_run++;
        else if (wen_run != 0) begin
            last_wen_len = wen_run;
            wen_run = 0;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          mbx;
        int          idx;
        bit          rd;
        logic [15:0] rdata;
        int          lat;
        bit          wr;
        logic [1:0]  wsel;
        logic [15:0] wdata;
        bit          mem;
        logic [15:0] caddr;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(bit mbx, int idx, bit rw, bit mm, logic [1:0] rg,
                                logic [15:0] a, logic [15:0] wd, logic [15:0] rdv);
        exp_t e;
        e.mbx   = mbx;
        e.idx   = idx;
        e.rd    = !rw;
        e.rdata = rdv;
        e.lat   = mm ? 7 : 4;
        e.wr    = rw || mm;
        e.wsel  = (mm && !rw) ? HPI_REG_ADDRESS : (mm ? HPI_REG_DATA : rg);
        e.wdata = rw ? wd : a;
        e.mem   = mm;
        e.caddr = a;
        return e;
    endfunction

    task automatic drive(input int i, input bit rw, input bit mm, input logic [1:0] rg,
                         input logic [15:0] a, input logic [15:0] wd);
        req_rw[i]  = rw;
        req_mem[i] = mm;
        t_reg[i]   = rg;
        t_addr[i]  = a;
        t_wdata[i] = wd;
        req[i]     = 1'b1;
    endtask

    task automatic wait_xfer(output logic gd, output logic gm, output int lat,
                             output logic [NREQ-1:0] g);
        gd = 1'b0; gm = 1'b0; lat = -1; g = '0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done || mbx_valid) begin
                gd  = done;
                gm  = mbx_valid;
                g   = gnt;
                lat = cyc - busy_start;
                return;
            end
        end
        chk("xfer_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_next();
        exp_t e;
        logic gd, gm;
        int lat;
        logic [NREQ-1:0] g;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        wait_xfer(gd, gm, lat, g);
        chk("xfer_kind", {30'd0, gd, gm}, e.mbx ? 32'd1 : 32'd2);
        chk("gnt", {30'd0, g}, e.mbx ? 32'd0 : (32'd1 << e.idx));
        chk("latency", lat, e.lat);
        if (e.rd) begin
            if (e.mbx) chk("mbx_data", {16'd0, mbx_data}, {16'd0, e.rdata});
            else       chk("rdata", {16'd0, rdata}, {16'd0, e.rdata});
        end
        if (e.wr) begin
            chk("wr_sel", {30'd0, last_wr_sel}, {30'd0, e.wsel});
            chk("wr_data", {16'd0, last_wr_data}, {16'd0, e.wdata});
            chk("wen_len", last_wen_len, 1);
        end
        if (e.mem) chk("chip_addr", {16'd0, chip_addr}, {16'd0, e.caddr});
    endtask

    task automatic apply_reset();
        req = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_csn", {31'd0, hpi_csn}, 32'd1);
        chk("rst_oen", {31'd0, hpi_oen}, 32'd1);
        chk("rst_wen", {31'd0, hpi_wen}, 32'd1);
        chk("rst_addr", {30'd0, hpi_address}, {30'd0, HPI_REG_STATUS});
        chk("rst_rdata", {16'd0, rdata}, 32'd0);
        chk("rst_mbx_valid", {31'd0, mbx_valid}, 32'd0);
        chk("rst_mbx_data", {16'd0, mbx_data}, 32'd0);
        chk("rst_resetn", {31'd0, hpi_resetn}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("resetn_rel", {31'd0, hpi_resetn}, 32'd1);
        sb.delete();
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < NREQ; i++) begin
            t_reg[i] = 2'b00; t_addr[i] = '0; t_wdata[i] = '0;
        end
        apply_reset();

        // single register write
        drive(0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'hA5A5);
        sb.push_back(mk(0, 0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'hA5A5, 16'h0000));
        check_next();
        req[0] = 1'b0;
        chk("host_mbx", {16'd0, host_mbx}, 32'h0000A5A5);

        // memory read by requester 1
        drive(1, 0, 1, HPI_REG_DATA, 16'h1324, 16'h0000);
        sb.push_back(mk(0, 1, 0, 1, HPI_REG_DATA, 16'h1324, 16'h0000, 16'hBEEF));
        check_next();
        req[1] = 1'b0;

        // a write leaves rdata untouched
        drive(0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'h0F0F);
        sb.push_back(mk(0, 0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'h0F0F, 16'h0000));
        check_next();
        req[0] = 1'b0;
        chk("rdata_held", {16'd0, rdata}, 32'h0000BEEF);

        // both held: strict alternation from pointer 0
        apply_reset();
        drive(0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'h1111);
        drive(1, 0, 0, HPI_REG_STATUS, 16'h0000, 16'h0000);
        for (int n = 0; n < 2; n++) begin
            sb.push_back(mk(0, 0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'h1111, 16'h0000));
            sb.push_back(mk(0, 1, 0, 0, HPI_REG_STATUS, 16'h0000, 16'h0000, 16'hC0DE));
        end
        for (int n = 0; n < 4; n++) check_next();
        req = '0;

        // drop request during phase A of a memory write
        drive(0, 1, 1, HPI_REG_DATA, 16'h0040, 16'h1234);
        sb.push_back(mk(0, 0, 1, 1, HPI_REG_DATA, 16'h0040, 16'h1234, 16'h0000));
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (gnt[0]) seen = 1'b1;
        end
        chk("gnt0_seen", {31'd0, seen}, 32'd1);
        repeat (2) @(negedge clk);
        req[0] = 1'b0;
        check_next();
        chk("mem_40", {16'd0, mem[8'h40]}, 32'h00001234);
        @(posedge clk);
        n_done = 0;
        repeat (12) @(negedge clk);
        chk("done_once", n_done, 0);

        // pointer moved past requester 0: requester 1 wins the tie
        drive(0, 0, 0, HPI_REG_STATUS, 16'h0000, 16'h0000);
        drive(1, 0, 0, HPI_REG_MAILBOX, 16'h0000, 16'h0000);
        sb.push_back(mk(0, 1, 0, 0, HPI_REG_MAILBOX, 16'h0000, 16'h0000, 16'h5A3C));
        sb.push_back(mk(0, 0, 0, 0, HPI_REG_STATUS, 16'h0000, 16'h0000, 16'hC0DE));
        check_next();
        req[1] = 1'b0;
        check_next();
        req[0] = 1'b0;

        // IRQ edge while requester 0 waits
        n_mbx = 0;
        drive(1, 0, 0, HPI_REG_STATUS, 16'h0000, 16'h0000);
        sb.push_back(mk(0, 1, 0, 0, HPI_REG_STATUS, 16'h0000, 16'h0000, 16'hC0DE));
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk("busy_seen", {31'd0, seen}, 32'd1);
        hpi_irq = 1'b1;
        drive(0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'h2222);
`ifdef HPI_IRQ_MBX_EN
        sb.push_back(mk(1, 0, 0, 0, HPI_REG_MAILBOX, 16'h0000, 16'h0000, 16'h5A3C));
`endif
        sb.push_back(mk(0, 0, 1, 0, HPI_REG_MAILBOX, 16'h0000, 16'h2222, 16'h0000));
        check_next();
        req[1] = 1'b0;
        hpi_irq = 1'b0;
`ifdef HPI_IRQ_MBX_EN
        check_next();
`endif
        check_next();
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
`ifdef HPI_IRQ_MBX_EN
        chk("mbx_pulses", n_mbx, 1);
        chk("mbx_data_hold", {16'd0, mbx_data}, 32'h00005A3C);
`else
        chk("mbx_pulses", n_mbx, 0);
        chk("mbx_data_zero", {16'd0, mbx_data}, 32'd0);
`endif

        // reset during the strobe of a write
        drive(0, 1, 0, HPI_REG_DATA, 16'h0000, 16'h7777);
        seen = 1'b0;
        for (int n = 0; n < 50 && !seen; n++) begin
            @(negedge clk);
            if (!hpi_wen) seen = 1'b1;
        end
        chk("wen_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_wen", {31'd0, hpi_wen}, 32'd1);
        chk("mid_rst_csn", {31'd0, hpi_csn}, 32'd1);
        chk("mid_rst_oen", {31'd0, hpi_oen}, 32'd1);
        chk("mid_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        req = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_gnt", {30'd0, gnt}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_csn", {31'd0, hpi_csn}, 32'd1);
        chk("no_partial_wr", {16'd0, mem[8'h40]}, 32'h00001234);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
